riscv_skid_pipe: RTL and testbench

//  Parametrised valid/ready pipeline register chain for inter-stage links in the RISC-V core.

---
 rtl/riscv_skid_pipe.sv | 133 +++++++++++++
 tb/tb_riscv_skid_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : riscv_skid_pipe
// Brief    : Valid/ready register chain of two-entry skid slices with a
//            registered in_ready and a synchronous flush. Optional occupancy
//            counter is enabled by defining RISCV_SKID_OCC_EN.
// Revision : 1.0
// ============================================================================
module riscv_skid_pipe #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_STAGES = 1,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef RISCV_SKID_OCC_EN
    ,
    output logic [$clog2(2*NUM_STAGES+1)-1:0] occupancy
`endif
);

    // Link k carries the handshake into stage k; link NUM_STAGES is the output.
    logic [NUM_STAGES:0]   w_valid;
    logic [NUM_STAGES:0]   w_ready;
    logic [DATA_WIDTH-1:0] w_data [NUM_STAGES+1];

    assign w_valid[0]          = in_valid;
    assign w_data[0]           = in_data;
    assign w_ready[NUM_STAGES] = out_ready;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                  main_vld_q, main_vld_d;
        logic                  skid_vld_q, skid_vld_d;
        logic [DATA_WIDTH-1:0] main_q, main_d;
        logic [DATA_WIDTH-1:0] skid_q, skid_d;
        logic                  rdy_q;
        logic                  w_in_fire;
        logic                  w_out_fire;

        assign w_in_fire  = w_valid[k] & rdy_q;
        assign w_out_fire = main_vld_q & w_ready[k+1];

        always_comb begin
            main_vld_d = main_vld_q;
            skid_vld_d = skid_vld_q;
            main_d     = main_q;
            skid_d     = skid_q;
            if (!main_vld_q) begin
                if (w_in_fire) begin
                    main_vld_d = 1'b1;
                    main_d     = w_data[k];
                end
            end else if (!skid_vld_q) begin
                if (w_in_fire && w_out_fire) begin
                    main_d = w_data[k];
                end else if (w_in_fire) begin
                    skid_vld_d = 1'b1;
                    skid_d     = w_data[k];
                end else if (w_out_fire) begin
                    main_vld_d = 1'b0;
                end
            end else if (w_out_fire) begin
                // rdy_q is low while full, so no input can arrive here.
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_vld_q <= 1'b0;
                skid_vld_q <= 1'b0;
                main_q     <= RST_VAL;
                skid_q     <= RST_VAL;
                rdy_q      <= 1'b1;
            end else if (flush) begin
                main_vld_q <= 1'b0;
                skid_vld_q <= 1'b0;
                main_q     <= RST_VAL;
                skid_q     <= RST_VAL;
                rdy_q      <= 1'b1;
            end else begin
                main_vld_q <= main_vld_d;
                skid_vld_q <= skid_vld_d;
                main_q     <= main_d;
                skid_q     <= skid_d;
                rdy_q      <= ~skid_vld_d;
            end
        end

        assign w_ready[k]   = rdy_q;
        assign w_valid[k+1] = main_vld_q;
        assign w_data[k+1]  = main_q;
    end

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[NUM_STAGES];
    assign out_data  = w_data[NUM_STAGES];

`ifdef RISCV_SKID_OCC_EN
    localparam int OCC_W = $clog2(2*NUM_STAGES+1);

    logic [OCC_W-1:0] occ_q;
    logic             w_top_in_fire;
    logic             w_top_out_fire;

    assign w_top_in_fire  = in_valid & in_ready;
    assign w_top_out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (w_top_in_fire && !w_top_out_fire) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (w_top_out_fire && !w_top_in_fire) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_skid_pipe
// Brief    : Directed and random bench for riscv_skid_pipe against a FIFO
//            queue model; occupancy checks are built with RISCV_SKID_OCC_EN.
// Revision : 1.0
// ============================================================================
module tb_riscv_skid_pipe;

    localparam int             DW  = 16;
    localparam int             NS  = 2;
    localparam int             CAP = 2 * NS;
    localparam logic [DW-1:0]  RV  = 16'hA5C3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
`ifdef RISCV_SKID_OCC_EN
    logic [$clog2(2*NS+1)-1:0] occupancy;
`endif

    int            checks = 0;
    int            failures = 0;
    int            pops = 0;
    logic [DW-1:0] q[$];
    logic          s_ir, s_ov, s_iv;
    logic [DW-1:0] s_od;

    always #5 clk = ~clk;

    riscv_skid_pipe #(
        .DATA_WIDTH (DW),
        .NUM_STAGES (NS),
        .RST_VAL    (RV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef RISCV_SKID_OCC_EN
        ,
        .occupancy (occupancy)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the FIFO model from the
    // observed handshakes, then return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_ir = in_ready;
        s_ov = out_valid;
        s_od = out_data;
        s_iv = in_valid;
        if (out_valid) begin
            chk("valid_with_items", 32'(q.size() > 0), 1);
            if (q.size() > 0) chk("fifo_order", out_data, q[0]);
        end
`ifdef RISCV_SKID_OCC_EN
        chk("occupancy_model", occupancy, q.size());
`endif
        chk("capacity", 32'(q.size() <= CAP), 1);
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (in_valid && in_ready) q.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, first, rise, p0, pushed, cyc;

        // Power-on reset
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, RV);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mid-cycle asynchronous reset with items held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h005A;
        tick();
        in_data   = 16'h005B;
        tick();
        in_valid  = 1'b0;
        tick();
        chk("t1_pre_valid", s_ov, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_out_valid", out_valid, 0);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_out_data", out_data, RV);
`ifdef RISCV_SKID_OCC_EN
        chk("t1_occupancy", occupancy, 0);
`endif
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back stream: latency NS cycles, one item per cycle
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            in_valid = (t < 8);
            in_data  = (t < 8) ? DW'(16'h11 + t) : DW'($urandom);
            tick();
            if (t < 8) chk("t2_in_ready", s_ir, 1);
            chk("t2_out_valid", s_ov, 32'(t >= 2 && t < 10));
            if (t >= 2 && t < 10) chk("t2_out_data", s_od, 16'h11 + t - 2);
        end

        // Backpressure: capacity 2*NS, then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int t = 0; t < 8; t++) begin
            in_data = DW'(16'h21 + acc);
            tick();
            if (s_ir) acc++;
        end
        chk("t3_accepted", acc, CAP);
        chk("t3_ready_low", s_ir, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        first = -1;
        rise  = -1;
        p0    = pops;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (first < 0 && s_ov) begin
                first = t;
                chk("t3_ready_at_first_out", s_ir, 0);
            end
            if (rise < 0 && s_ir) rise = t;
        end
        chk("t3_drained", pops - p0, CAP);
        chk("t3_ready_rise", 32'(first >= 0 && rise > first && rise <= first + 2), 1);

        // Random valid/ready traffic, junk data while in_valid is low
        pushed = 0;
        p0     = pops;
        cyc    = 0;
        while ((pops - p0) < 1000 && cyc < 20000) begin
            in_valid  = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = DW'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (s_iv && s_ir) pushed++;
            cyc++;
        end
        chk("t4_items_out", pops - p0, 1000);
        chk("t4_model_empty", q.size(), 0);

        // Flush while full with a pending input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_data = DW'(16'h31 + t);
            tick();
        end
        chk("t5_full", q.size(), CAP);
        flush   = 1'b1;
        in_data = 16'h0099;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("t5_out_valid", s_ov, 0);
        chk("t5_in_ready", s_ir, 1);
        chk("t5_out_data", s_od, RV);
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("t5_no_stale", s_ov, 0);
        end

`ifdef RISCV_SKID_OCC_EN
        // Occupancy counter
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int t = 0; t < 3; t++) begin
            in_data = DW'(16'h41 + t);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t6_occ_three", occupancy, 3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 16'h0044;
        tick();
        chk("t6_both_fire", 32'(s_ir && s_ov), 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6_occ_net_zero", occupancy, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_occ_flush", occupancy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
